// File: rtl/surf5_pps_pkg.sv
// ----------------------------------------------------------------------------
// surf5_pps_pkg
// Shared definitions for the SURF5 PPS source selection / generation stage.
//   mode_e  : encoding of mode_i (driven from pps_sel_reg[1:0])
//   state_e : encoding of state_o
//   CNT_W   : width of the free-running period counter and period_o
// ----------------------------------------------------------------------------
package surf5_pps_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        MODE_EXT      = 2'b00,  // follow external PPS, drop to ACQ on loss
        MODE_INT      = 2'b01,  // free-running internal PPS
        MODE_EXT_HOLD = 2'b10,  // follow external PPS, free-run through loss
        MODE_DIS      = 2'b11   // no PPS output at all
    } mode_e;

    typedef enum logic [1:0] {
        ST_ACQ  = 2'b00,        // waiting for first external edge
        ST_LOCK = 2'b01,        // tracking qualified external edges
        ST_HOLD = 2'b10,        // external lost, synthesizing ticks
        ST_INT  = 2'b11         // internal generator
    } state_e;

endpackage

// File: rtl/surf5_pps_sync.sv
// ----------------------------------------------------------------------------
// surf5_pps_sync
// Three-flop synchroniser for the raw PPS pin plus rising-edge detect.
// The first two flops resolve metastability; the third holds the previous
// synchronised level so the edge strobe is one clk_i cycle wide.
// Ports:
//   clk_i    in  1  system clock
//   rst_n_i  in  1  asynchronous active-low reset
//   d_i      in  1  asynchronous input (raw PPS pin)
//   rise_o   out 1  one-cycle strobe, high the cycle after ff2 first sees 1
// ----------------------------------------------------------------------------
module surf5_pps_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic rise_o
);

    logic ff1_q;
    logic ff2_q;
    logic ff3_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
            ff3_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
            ff3_q <= ff2_q;
        end
    end

    assign rise_o = ff2_q & ~ff3_q;

endmodule

// File: rtl/surf5_pps_ctrl.sv
// ----------------------------------------------------------------------------
// surf5_pps_ctrl
// PPS source selection / generation stage. Synchronises the raw PPS pin,
// qualifies its edges against the expected one-second period, measures the
// ext-to-ext period, flags loss of the external reference and optionally
// free-runs an internal PPS (standalone or as holdover).
// Ports:
//   clk_i          in  1   system clock
//   rst_n_i        in  1   asynchronous active-low reset
//   mode_i         in  2   00 EXT, 01 INT, 10 EXT_HOLD, 11 DISABLED
//   pps_i          in  1   raw PPS pin, asynchronous
//   pps_o          out 1   stretched PPS pulse, PULSE_W cycles
//   pps_sysclk_o   out 1   one-cycle PPS event flag
//   period_o       out 32  last measured ext-edge-to-ext-edge period
//   period_valid_o out 1   period_o measured since last mode change/reset
//   lost_o         out 1   expected external PPS missed
//   lost_irq_o     out 1   one-cycle pulse on lost_o rising
//   state_o        out 2   00 ACQ, 01 LOCK, 10 HOLD, 11 INT
// ----------------------------------------------------------------------------
module surf5_pps_ctrl
    import surf5_pps_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TOL     = 1_000,
    parameter int unsigned PULSE_W = 10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  mode_i,
    input  logic        pps_i,
    output logic        pps_o,
    output logic        pps_sysclk_o,
    output logic [31:0] period_o,
    output logic        period_valid_o,
    output logic        lost_o,
    output logic        lost_irq_o,
    output logic [1:0]  state_o
);

    // The loss threshold must be reachable by a non-saturated counter, and
    // the acceptance window must not underflow.
    localparam logic [63:0] LOSS_SUM = 64'(CLK_HZ) + 64'(TOL);
    if (LOSS_SUM >= 64'h0000_0000_FFFF_FFFF) begin : g_bad_loss
        $error("surf5_pps_ctrl: CLK_HZ+TOL must be below 2^32-1");
    end
    if (64'(CLK_HZ) <= 64'(TOL) + 64'd1) begin : g_bad_win
        $error("surf5_pps_ctrl: CLK_HZ must exceed TOL+1");
    end

    localparam logic [CNT_W-1:0] TICK   = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(CLK_HZ - TOL - 1);
    localparam logic [CNT_W-1:0] LOSS   = CNT_W'(CLK_HZ + TOL);
    localparam int               PW     = $clog2(PULSE_W + 1);

    logic ext_edge;

    surf5_pps_sync u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (pps_i),
        .rise_o  (ext_edge)
    );

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    mode_e            mode_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    pcnt_q;
    logic             pps_q;
    logic             sys_q;
    logic [CNT_W-1:0] per_q;
    logic             pv_q;
    logic             lost_q;
    logic             irq_q;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic   mode_chg;
    logic   ev;         // one-cycle PPS event strobe
    logic   lost_set;
    logic   lost_clr;
    logic   per_upd;
    state_e state_d;
    logic   in_win;

    assign mode_chg = (mode_i != mode_q);
    // Edges arriving early in the second are glitches, not PPS.
    assign in_win   = ext_edge && (cnt_q >= WIN_LO);

    always_comb begin
        ev       = 1'b0;
        lost_set = 1'b0;
        lost_clr = 1'b0;
        per_upd  = 1'b0;
        state_d  = state_q;
        if (mode_chg) begin
            state_d = (mode_e'(mode_i) == MODE_INT) ? ST_INT : ST_ACQ;
        end else begin
            case (mode_q)
                MODE_INT: begin
                    state_d = ST_INT;
                    ev      = (cnt_q == TICK);
                end
                MODE_DIS: begin
                    state_d = ST_ACQ;
                end
                default: begin
                    case (state_q)
                        ST_ACQ: begin
                            // First edge is trusted blindly; period not
                            // measured since there is no prior reference.
                            if (ext_edge) begin
                                ev       = 1'b1;
                                lost_clr = 1'b1;
                                state_d  = ST_LOCK;
                            end
                        end
                        ST_LOCK: begin
                            if (in_win) begin
                                ev       = 1'b1;
                                per_upd  = 1'b1;
                                lost_clr = 1'b1;
                            end else if (cnt_q >= LOSS) begin
                                lost_set = 1'b1;
                                if (mode_q == MODE_EXT_HOLD) begin
                                    // Late tick stands in for the missing edge.
                                    ev      = 1'b1;
                                    state_d = ST_HOLD;
                                end else begin
                                    state_d = ST_ACQ;
                                end
                            end
                        end
                        ST_HOLD: begin
                            // An edge coinciding with the internal tick is
                            // a single event that also re-locks.
                            if (in_win) begin
                                ev       = 1'b1;
                                lost_clr = 1'b1;
                                state_d  = ST_LOCK;
                            end else if (cnt_q == TICK) begin
                                ev = 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_ACQ;
                        end
                    endcase
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q  <= MODE_EXT;
            state_q <= ST_ACQ;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            pps_q   <= 1'b0;
            sys_q   <= 1'b0;
            per_q   <= '0;
            pv_q    <= 1'b0;
            lost_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            mode_q  <= mode_e'(mode_i);
            state_q <= state_d;
            sys_q   <= ev;
            if (mode_chg) begin
                cnt_q  <= '0;
                pcnt_q <= '0;
                pps_q  <= 1'b0;
                pv_q   <= 1'b0;
                lost_q <= 1'b0;
                irq_q  <= 1'b0;
            end else begin
                if (ev) begin
                    cnt_q <= '0;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end

                // Every event reloads the full width, so overlapping events
                // extend the pulse rather than truncating it.
                if (ev) begin
                    pcnt_q <= PW'(PULSE_W);
                    pps_q  <= 1'b1;
                end else if (pcnt_q != '0) begin
                    pcnt_q <= pcnt_q - PW'(1);
                    pps_q  <= (pcnt_q > PW'(1));
                end

                if (per_upd) begin
                    per_q <= cnt_q + CNT_W'(1);
                    pv_q  <= 1'b1;
                end

                if (lost_set) begin
                    lost_q <= 1'b1;
                end else if (lost_clr) begin
                    lost_q <= 1'b0;
                end
                irq_q <= lost_set & ~lost_q;
            end
        end
    end

    assign pps_o          = pps_q;
    assign pps_sysclk_o   = sys_q;
    assign period_o       = per_q;
    assign period_valid_o = pv_q;
    assign lost_o         = lost_q;
    assign lost_irq_o     = irq_q;
    assign state_o        = state_q;

endmodule
